// File: rtl/mem_port_arbiter_if.sv
// Bundle of the pipeline-side (IF / MEM stage) and memory-side signals of the
// unified memory port. The arbiter uses the master view, the environment uses the slave view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;

    logic              dm_read;
    logic              dm_write;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_done;
    logic              dm_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic              err;

    modport master (
        input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata,
        input  mem_rdata, mem_ack,
        output if_rdata, if_valid, if_stall, dm_rdata, dm_done, dm_stall,
        output mem_req, mem_we, mem_addr, mem_wdata, err
    );

    modport slave (
        output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata,
        output mem_rdata, mem_ack,
        input  if_rdata, if_valid, if_stall, dm_rdata, dm_done, dm_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the MEM stage: data beats
// fetch, one access at a time, RESP gap between accesses, watchdog abort on missing ack.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mem_port_arbiter_if.master bus
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DM_BUSY = 2'd1,
        ST_IF_BUSY = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    state_e            state_q,     state_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
    logic              if_valid_q,  if_valid_d;
    logic              dm_done_q,   dm_done_d;
    logic              err_q,       err_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;

    logic              dm_any_s;
    logic              expired_s;

    assign dm_any_s  = bus.dm_read | bus.dm_write;
    assign expired_s = (cnt_q == CNT_LAST);

    // State and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_done_q   <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_done_q   <= dm_done_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Grant, busy/ack/watchdog sequencing and response pulse generation
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_done_d   = 1'b0;
        err_d       = err_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                // A pending load/store belongs to an older instruction than the fetch.
                if (dm_any_s) begin
                    state_d     = ST_DM_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dm_write;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    cnt_d       = '0;
                end else if (bus.if_req) begin
                    state_d     = ST_IF_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    cnt_d       = '0;
                end else begin
                    state_d     = ST_IDLE;
                end
            end

            ST_DM_BUSY: begin
                if (bus.mem_ack) begin
                    state_d    = ST_RESP;
                    mem_req_d  = 1'b0;
                    dm_done_d  = 1'b1;
                    dm_rdata_d = mem_we_q ? '0 : bus.mem_rdata;
                end else if (expired_s) begin
                    state_d    = ST_RESP;
                    mem_req_d  = 1'b0;
                    dm_done_d  = 1'b1;
                    dm_rdata_d = '0;
                    err_d      = 1'b1;
                end else begin
                    cnt_d      = cnt_q + CNT_ONE;
                end
            end

            ST_IF_BUSY: begin
                if (bus.mem_ack) begin
                    state_d    = ST_RESP;
                    mem_req_d  = 1'b0;
                    if_valid_d = 1'b1;
                    if_rdata_d = bus.mem_rdata;
                end else if (expired_s) begin
                    state_d    = ST_RESP;
                    mem_req_d  = 1'b0;
                    if_valid_d = 1'b1;
                    if_rdata_d = '0;
                    err_d      = 1'b1;
                end else begin
                    cnt_d      = cnt_q + CNT_ONE;
                end
            end

            ST_RESP: begin
                // Requester inputs still describe the finished access here, so never grant.
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.err       = err_q;

    // Stalls depend only on requests and registered pulses, never on mem_ack.
    assign bus.if_stall  = bus.if_req & ~if_valid_q;
    assign bus.dm_stall  = dm_any_s & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level memory/arbitration model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit exp_err = 1'b0;
    logic [31:0] mem_model [logic [31:0]];

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'h0;
        bus.dm_read   = 1'b0;
        bus.dm_write  = 1'b0;
        bus.dm_addr   = 32'h0;
        bus.dm_wdata  = 32'h0;
        bus.mem_rdata = 32'h0;
        bus.mem_ack   = 1'b0;
    endtask

    // Called in the first busy cycle; returns in the idle cycle after the response.
    task automatic serve(input bit is_dm, input logic [31:0] addr, input bit we,
                         input logic [31:0] wd, input int lat, input bit drop,
                         input string nm);
        logic [31:0] rd_exp;
        int          ncyc;
        ncyc   = (lat == 0) ? TO : lat;
        rd_exp = 32'h0;
        for (int c = 1; c <= ncyc; c++) begin
            total++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== addr || bus.mem_we !== we) begin
                bad++;
                $display("FAIL %s busy%0d req/addr/we: got %b/%h/%b want 1/%h/%b",
                         nm, c, bus.mem_req, bus.mem_addr, bus.mem_we, addr, we);
            end
            if (we) begin
                total++;
                if (bus.mem_wdata !== wd) begin
                    bad++;
                    $display("FAIL %s busy%0d wdata: got %h want %h", nm, c, bus.mem_wdata, wd);
                end
            end
            total++;
            if (bus.if_valid !== 1'b0 || bus.dm_done !== 1'b0 || bus.err !== exp_err) begin
                bad++;
                $display("FAIL %s busy%0d pulses/err: got %b/%b/%b want 0/0/%b",
                         nm, c, bus.if_valid, bus.dm_done, bus.err, exp_err);
            end
            total++;
            if (bus.if_stall !== bus.if_req || bus.dm_stall !== (bus.dm_read | bus.dm_write)) begin
                bad++;
                $display("FAIL %s busy%0d stalls: got %b/%b want %b/%b", nm, c,
                         bus.if_stall, bus.dm_stall, bus.if_req, bus.dm_read | bus.dm_write);
            end
            if (drop && c == 1) begin
                if (is_dm) begin
                    bus.dm_read  = 1'b0;
                    bus.dm_write = 1'b0;
                end else begin
                    bus.if_req = 1'b0;
                end
            end
            if (c == lat) begin
                bus.mem_ack = 1'b1;
                if (we) begin
                    bus.mem_rdata = $urandom;
                end else begin
                    rd_exp        = model_read(addr);
                    bus.mem_rdata = rd_exp;
                end
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
            end
            tick;
        end
        bus.mem_ack = 1'b0;
        if (lat == 0) exp_err = 1'b1;
        else if (we) mem_model[addr] = wd;

        total++;
        if (bus.dm_done !== is_dm || bus.if_valid !== !is_dm || bus.mem_req !== 1'b0) begin
            bad++;
            $display("FAIL %s resp done/valid/req: got %b/%b/%b want %b/%b/0",
                     nm, bus.dm_done, bus.if_valid, bus.mem_req, is_dm, !is_dm);
        end
        total++;
        if ((is_dm ? bus.dm_rdata : bus.if_rdata) !== rd_exp) begin
            bad++;
            $display("FAIL %s resp rdata: got %h want %h", nm,
                     is_dm ? bus.dm_rdata : bus.if_rdata, rd_exp);
        end
        total++;
        if (bus.err !== exp_err) begin
            bad++;
            $display("FAIL %s resp err: got %b want %b", nm, bus.err, exp_err);
        end
        total++;
        if (bus.if_stall !== (bus.if_req & is_dm) ||
            bus.dm_stall !== ((bus.dm_read | bus.dm_write) & !is_dm)) begin
            bad++;
            $display("FAIL %s resp stalls: got %b/%b want %b/%b", nm, bus.if_stall,
                     bus.dm_stall, bus.if_req & is_dm, (bus.dm_read | bus.dm_write) & !is_dm);
        end
        if (is_dm) begin
            bus.dm_read  = 1'b0;
            bus.dm_write = 1'b0;
        end else begin
            bus.if_req = 1'b0;
        end
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        tick;
        bus.mem_ack = 1'b0;
        total++;
        if (bus.mem_req !== 1'b0 || bus.dm_done !== 1'b0 || bus.if_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s gap req/done/valid: got %b/%b/%b want 0/0/0",
                     nm, bus.mem_req, bus.dm_done, bus.if_valid);
        end
    endtask

    task automatic test_reset;
        clear_inputs();
        rst         = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h40;
        tick;
        tick;
        total++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_rdata,
             bus.dm_rdata, bus.if_valid, bus.dm_done, bus.err, bus.dm_stall} !== 136'h0) begin
            bad++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h wd=%h ird=%h drd=%h v=%b d=%b err=%b ds=%b want all 0",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_rdata,
                     bus.dm_rdata, bus.if_valid, bus.dm_done, bus.err, bus.dm_stall);
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.mem_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_req: got %b want 0", bus.mem_req);
        end
        tick;
        serve(1'b0, 32'h40, 1'b0, 32'h0, 2, 1'b0, "reset_first_fetch");
    endtask

    task automatic test_if_fetch;
        mem_model[32'h1000] = 32'h8C22_0004;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h1000;
        tick;
        serve(1'b0, 32'h1000, 1'b0, 32'h0, 1, 1'b0, "if_fetch");
    endtask

    task automatic test_simultaneous;
        bus.dm_read = 1'b1;
        bus.dm_addr = 32'h100;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h40;
        #1;
        total++;
        if (bus.if_stall !== 1'b1 || bus.dm_stall !== 1'b1) begin
            bad++;
            $display("FAIL simul_stalls_idle: got %b/%b want 1/1", bus.if_stall, bus.dm_stall);
        end
        tick;
        serve(1'b1, 32'h100, 1'b0, 32'h0, 3, 1'b0, "simul_dm");
        tick;
        serve(1'b0, 32'h40, 1'b0, 32'h0, 3, 1'b0, "simul_if");
    endtask

    task automatic test_store;
        bus.dm_write = 1'b1;
        bus.dm_addr  = 32'h200;
        bus.dm_wdata = 32'hDEAD_BEEF;
        tick;
        serve(1'b1, 32'h200, 1'b1, 32'hDEAD_BEEF, 3, 1'b0, "store");
        bus.dm_read = 1'b1;
        bus.dm_addr = 32'h200;
        tick;
        serve(1'b1, 32'h200, 1'b0, 32'h0, 1, 1'b0, "store_readback");
    endtask

    task automatic test_read_write_both;
        bus.dm_read  = 1'b1;
        bus.dm_write = 1'b1;
        bus.dm_addr  = 32'h204;
        bus.dm_wdata = 32'h1234_5678;
        tick;
        serve(1'b1, 32'h204, 1'b1, 32'h1234_5678, 2, 1'b0, "rw_both");
    endtask

    task automatic test_spurious;
        for (int i = 0; i < 3; i++) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = $urandom;
            tick;
            total++;
            if (bus.mem_req !== 1'b0 || bus.dm_done !== 1'b0 || bus.if_valid !== 1'b0) begin
                bad++;
                $display("FAIL spurious_ack%0d: got req/done/valid %b/%b/%b want 0/0/0",
                         i, bus.mem_req, bus.dm_done, bus.if_valid);
            end
        end
        bus.mem_ack = 1'b0;
        bus.dm_read = 1'b1;
        bus.dm_addr = 32'h208;
        tick;
        serve(1'b1, 32'h208, 1'b0, 32'h0, 2, 1'b0, "after_spurious");
    endtask

    task automatic test_random(input int iters, input int lat_min, input string nm);
        int          pat;
        bit          dm_we;
        logic [31:0] da, ia, wd;
        for (int n = 0; n < iters; n++) begin
            pat   = $urandom_range(0, 4);
            da    = 32'h400 + 32'($urandom_range(0, 7)) * 32'd4;
            ia    = 32'h800 + 32'($urandom_range(0, 7)) * 32'd4;
            wd    = $urandom;
            dm_we = 1'b0;
            bus.dm_addr  = da;
            bus.dm_wdata = wd;
            bus.if_addr  = ia;
            case (pat)
                0: bus.if_req = 1'b1;
                1: bus.dm_read = 1'b1;
                2: begin bus.dm_write = 1'b1; dm_we = 1'b1; end
                3: begin bus.dm_read = 1'b1; bus.dm_write = 1'b1; dm_we = 1'b1; end
                default: begin
                    bus.if_req = 1'b1;
                    if ($urandom_range(0, 1) == 0) bus.dm_read = 1'b1;
                    else begin bus.dm_write = 1'b1; dm_we = 1'b1; end
                end
            endcase
            tick;
            if (pat != 0) begin
                serve(1'b1, da, dm_we, wd, $urandom_range(lat_min, 6),
                      1'($urandom_range(0, 3) == 0), nm);
                if (pat == 4) tick;
            end
            if (pat == 0 || pat == 4) begin
                serve(1'b0, ia, 1'b0, 32'h0, $urandom_range(lat_min, 6),
                      1'($urandom_range(0, 3) == 0), nm);
            end
            repeat ($urandom_range(0, 2)) tick;
        end
    endtask

    task automatic test_timeout;
        bus.dm_read = 1'b1;
        bus.dm_addr = 32'h300;
        tick;
        serve(1'b1, 32'h300, 1'b0, 32'h0, 0, 1'b0, "timeout");
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h1000;
        tick;
        serve(1'b0, 32'h1000, 1'b0, 32'h0, 2, 1'b0, "err_sticky");
    endtask

    task automatic test_mid_reset;
        bus.dm_read = 1'b1;
        bus.dm_addr = 32'h300;
        tick;
        total++;
        if (bus.mem_req !== 1'b1) begin
            bad++;
            $display("FAIL midrst_grant: got %b want 1", bus.mem_req);
        end
        tick;
        rst = 1'b1;
        tick;
        exp_err = 1'b0;
        total++;
        if (bus.mem_req !== 1'b0 || bus.dm_done !== 1'b0 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL midrst_abort: got req/done/err %b/%b/%b want 0/0/0",
                     bus.mem_req, bus.dm_done, bus.err);
        end
        rst         = 1'b0;
        bus.dm_read = 1'b0;
        tick;
        total++;
        if (bus.mem_req !== 1'b0 || bus.dm_done !== 1'b0) begin
            bad++;
            $display("FAIL midrst_no_done: got req/done %b/%b want 0/0", bus.mem_req, bus.dm_done);
        end
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h1000;
        tick;
        serve(1'b0, 32'h1000, 1'b0, 32'h0, 1, 1'b0, "after_midrst");
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_if_fetch();
        test_simultaneous();
        test_store();
        test_read_write_both();
        test_spurious();
        test_random(40, 1, "rand_ok");
        test_timeout();
        test_random(20, 0, "rand_to");
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter sharing the single unified memory port of the pipelined MIPS core between instruction fetch (IF) and the data-memory stage (MEM). It grants one requester at a time, drives a request/acknowledge handshake to a variable-latency memory and raises per-port stall signals that the pipeline ORs into its global stall, next to the hazard unit's IF_write/PC_write controls. A watchdog aborts accesses the memory never acknowledges.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 64, cycles in a busy state without mem_ack before abort (≥2)

- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  reset; synchronous, active-high
- if_req  in  1  IF wants an instruction word
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, valid while if_valid
- if_valid  out  1  one-cycle completion pulse for IF
- if_stall  out  1  if_req & ~if_valid (combinational)
- dm_read, dm_write  in  1  MEM-stage load/store request
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, valid while dm_done
- dm_done  out  1  one-cycle completion pulse for MEM
- dm_stall  out  1  (dm_read|dm_write) & ~dm_done (combinational)
- mem_req  out  1  memory request, registered
- mem_we  out  1  write enable, registered
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  read data, valid in the mem_ack cycle
- mem_ack  in  1  one-cycle acknowledge from memory
- err  out  1  sticky timeout flag; cleared only by Rst

## Operation
- States: IDLE, DM_BUSY, IF_BUSY, RESP.
- IDLE: if dm_read|dm_write → latch dm_addr/dm_wdata, mem_we=dm_write, go DM_BUSY; else if if_req → latch if_addr, mem_we=0, go IF_BUSY; else stay. Data always beats fetch (older instruction).
- dm_read and dm_write both high: performed as a write; dm_rdata returns 0.
- DM_BUSY/IF_BUSY: mem_req=1, mem_addr/we/wdata held constant; on mem_ack capture mem_rdata into the owner's rdata register, go RESP.
- RESP (1 cycle): pulse owner's done/valid; no new grant regardless of requests (requester's inputs still show the finished access); mem_req=0; next IDLE.
- Timeout: busy-cycle counter reset on grant; at count TIMEOUT without ack → set err, owner's rdata=0, go RESP (done pulse still issued so pipeline does not hang).
- mem_ack in IDLE or RESP: ignored, no state change.
- Requester dropping its request while its access is busy: access still completes; pulse issued in RESP.

## Timing
- Reset values: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, dm_rdata=0, if_valid=0, dm_done=0, err=0, counter=0.
- Rst asserted mid-access: mem_req low the cycle after the reset edge; in-flight access abandoned, no done pulse.
- Request sampled in IDLE cycle 0 → mem_req high from cycle 1; mem_ack in cycle k (k≥1) → done/valid in cycle k+1 → IDLE at k+2. Zero-wait memory (ack in cycle 1): 3 cycles per access.
- mem_req is low for at least one cycle (RESP) between consecutive transactions.
- Simultaneous IF and MEM requests: MEM served first; IF grant no earlier than 2 cycles after dm_done.
- Stall outputs are combinational from requests and registered pulses; no combinational path from mem_ack.

## Test plan
- Reset: Rst high 2 cycles with if_req=1 → all outputs 0, state IDLE, mem_req stays 0 until cycle after Rst falls.
- IF fetch, ack at cycle 1, mem_rdata=0x8C220004 → mem_req cycle 1 only, if_valid and if_rdata=0x8C220004 cycle 2, if_stall low cycle 2.
- Simultaneous dm_read @0x100 and if_req @0x40, ack 3 cycles after each mem_req rise → first mem_addr=0x100 mem_we=0, second 0x40; dm_stall high until dm_done, if_stall high until if_valid.
- Store: dm_write with dm_addr=0x200, dm_wdata=0xDEADBEEF → mem_we=1, mem_wdata=0xDEADBEEF held stable until ack, dm_done next cycle.
- Timeout: TIMEOUT=8, no ack → after 8 busy cycles dm_done pulses, dm_rdata=0, err=1 and stays 1 until Rst.
- Spurious/mid-reset: mem_ack pulsed in IDLE → no transition; Rst during DM_BUSY → mem_req low next cycle, no dm_done.
